// File: rtl/led_mode_selector.sv
// Two-button (next/prev) synchronised, debounced mode stepper for the LED pattern generator.
// Define LONG_PRESS_EN to make a long hold of btn_next force mode back to 0.
module led_mode_selector #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  output logic [1:0] mode,
  output logic       mode_chg
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'hFF_FFFF ||
      LONG_CYCLES < 2 || LONG_CYCLES > 32'hFF_FFFF) begin : g_bad_param
    $error("led_mode_selector: DEBOUNCE_CYCLES/LONG_CYCLES out of range 2..2^24-1");
  end

  logic [1:0] raw;
  logic [1:0] acc;
  logic       long_hit;

  assign raw = {btn_prev, btn_next};

  // Index 0 is btn_next, index 1 is btn_prev; both get the same sync + debounce FSM.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0]  sync;
    logic        s;
    state_t      state;
    logic [23:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync <= 2'b00;
      end else begin
        sync <= {sync[0], raw[i]};
      end
    end

    assign s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (s) begin
              state <= DEB_PRESS;
              cnt   <= '0;
            end
          end
          DEB_PRESS: begin
            if (!s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= PRESSED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          PRESSED: begin
            if (!s) begin
              state <= DEB_RELEASE;
              cnt   <= '0;
            end
`ifdef LONG_PRESS_EN
            else if (cnt != 24'(LONG_CYCLES - 1)) begin
              cnt <= cnt + 24'd1;
            end
`endif
          end
          DEB_RELEASE: begin
            if (s) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign acc[i] = (state == DEB_PRESS) && s && (cnt == DEB_LAST);
  end

`ifdef LONG_PRESS_EN
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

  logic long_done;

  // Fires once when the saturated hold count is seen; re-armed only by leaving PRESSED.
  assign long_hit = (g_btn[0].state == PRESSED) && g_btn[0].s &&
                    (g_btn[0].cnt == LONG_LAST) && !long_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_done <= 1'b0;
    end else if (g_btn[0].state != PRESSED) begin
      long_done <= 1'b0;
    end else if (long_hit) begin
      long_done <= 1'b1;
    end
  end
`else
  assign long_hit = 1'b0;
`endif

  // Simultaneous next+prev acceptances cancel; a long-press reset overrides a prev press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= 2'b00;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      if (long_hit) begin
        if (mode != 2'b00) begin
          mode     <= 2'b00;
          mode_chg <= 1'b1;
        end
      end else if (acc == 2'b01) begin
        mode     <= mode + 2'd1;
        mode_chg <= 1'b1;
      end else if (acc == 2'b10) begin
        mode     <= mode - 2'd1;
        mode_chg <= 1'b1;
      end
    end
  end

endmodule
